// File: rtl/rr_arbiter.sv
// Round-robin arbiter with single-owner hold, release on done / request drop,
// and an optional hold-cycle timeout. All outputs are registered.
module rr_arbiter #(
    parameter int NR  = 4,
    parameter int KW  = 3,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NR-1:0] req,
    input  logic          done,
    output logic [NR-1:0] grant,
    output logic [KW-1:0] grant_idx,
    output logic          busy,
    output logic          timeout
);

    localparam int PW = (NR > 1) ? $clog2(NR) : 1;
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int unsigned NRU = NR;
    localparam logic [CW-1:0] CMAX = (TMO > 0) ? CW'(TMO - 1) : '0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NR-1:0] grant_q, grant_d;
    logic [KW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          tmo_q, tmo_d;

    logic          found;
    logic [PW-1:0] sel;
    int unsigned   pos;
    logic          rel_owner;
    logic          tmo_hit;

    // Circular priority scan: first requester at or after ptr_q.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < NRU; k++) begin
            pos = k + ptr_q;
            if (pos >= NRU) begin
                pos = pos - NRU;
            end
            if (!found && req[pos[PW-1:0]]) begin
                found = 1'b1;
                sel   = pos[PW-1:0];
            end
        end
    end

    // Release qualifiers for the current owner.
    always_comb begin
        rel_owner = done || !req[own_q];
        tmo_hit   = (TMO > 0) && (cnt_q == CMAX);
    end

    // Next-state logic for the IDLE/HOLD controller and registered outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    own_d        = sel;
                    idx_d        = KW'(sel) + KW'(1);
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_HOLD;
                end
            end
            default: begin
                if (rel_owner || tmo_hit) begin
                    grant_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    // timeout only flags a release forced by the counter alone
                    tmo_d   = !rel_owner;
                    ptr_d   = (own_q == PW'(NR - 1)) ? '0 : own_q + PW'(1);
                    state_d = ST_IDLE;
                end else if (cnt_q != CMAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = busy_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NR=4, KW=3, TMO=8 and TMO=0).
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    logic [3:0] req1;
    logic       done1;
    logic [3:0] grant1;
    logic [2:0] grant_idx1;
    logic       busy1;
    logic       timeout1;

    int total = 0;
    int bad   = 0;

    rr_arbiter #(.NR(4), .KW(3), .TMO(8)) u0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    rr_arbiter #(.NR(4), .KW(3), .TMO(0)) u1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .done      (done1),
        .grant     (grant1),
        .grant_idx (grant_idx1),
        .busy      (busy1),
        .timeout   (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [2:0] idx,
                           input logic b, input logic t);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned seq [5] = '{1, 2, 3, 4, 1};
        logic [3:0] gexp;

        rst = 1'b1; req = '0; done = 1'b0; req1 = '0; done1 = 1'b0;
        step();
        step();
        chk_out("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("reset.ptr", 32'(u0.ptr_q), 32'd0);
        rst = 1'b0;

        // rotation with all requesters active
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            gexp = 4'b0001 << (seq[i] - 1);
            step();
            chk_out("rot.grant", gexp, 3'(seq[i]), 1'b1, 1'b0);
            done = 1'b1;
            step();
            chk_out("rot.idle", 4'b0000, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
        end
        req = '0;
        chk("rot.ptr", 32'(u0.ptr_q), 32'd1);

        // single request after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("single.ptr0", 32'(u0.ptr_q), 32'd0);
        req = 4'b0100;
        step();
        chk_out("single.grant", 4'b0100, 3'd3, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_out("single.rel", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("single.ptr", 32'(u0.ptr_q), 32'd3);
        done = 1'b0;

        // wrap priority from ptr=3
        req = 4'b1001;
        step();
        chk_out("wrap.hi", 4'b1000, 3'd4, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_out("wrap.rel1", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("wrap.ptr0", 32'(u0.ptr_q), 32'd0);
        done = 1'b0;
        step();
        chk_out("wrap.lo", 4'b0001, 3'd1, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk("wrap.ptr1", 32'(u0.ptr_q), 32'd1);
        done = 1'b0;
        req = '0;

        // timeout with other requests changing underneath the owner
        req = 4'b0010;
        step();
        chk_out("tmo.grant", 4'b0010, 3'd2, 1'b1, 1'b0);
        req = 4'b1110;
        for (int i = 1; i < 8; i++) begin
            step();
            chk_out("tmo.hold", 4'b0010, 3'd2, 1'b1, 1'b0);
        end
        step();
        chk_out("tmo.rel", 4'b0000, 3'd0, 1'b0, 1'b1);
        chk("tmo.ptr", 32'(u0.ptr_q), 32'd2);
        req = '0;
        step();
        chk_out("tmo.pulse_end", 4'b0000, 3'd0, 1'b0, 1'b0);

        // done coinciding with the timeout edge counts as a normal release
        req = 4'b0010;
        step();
        chk_out("coin.grant", 4'b0010, 3'd2, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk_out("coin.hold", 4'b0010, 3'd2, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        chk_out("coin.rel", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("coin.ptr", 32'(u0.ptr_q), 32'd2);
        done = 1'b0;
        req = '0;

        // done is ignored while idle
        done = 1'b1;
        step();
        chk_out("idledone.none", 4'b0000, 3'd0, 1'b0, 1'b0);
        req = 4'b0001;
        step();
        chk_out("idledone.grant", 4'b0001, 3'd1, 1'b1, 1'b0);
        step();
        chk_out("idledone.rel", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("idledone.ptr", 32'(u0.ptr_q), 32'd1);
        done = 1'b0;
        req = '0;

        // asynchronous reset in the middle of a hold
        req = 4'b0100;
        step();
        chk_out("mid.grant", 4'b0100, 3'd3, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("mid.async", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("mid.ptr", 32'(u0.ptr_q), 32'd0);
        rst = 1'b0;
        req = 4'b0010;
        step();
        chk_out("mid.regrant", 4'b0010, 3'd2, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk("mid.ptr2", 32'(u0.ptr_q), 32'd2);
        done = 1'b0;
        req = '0;

        // timeout disabled: grant held indefinitely
        req1 = 4'b0001;
        step();
        chk("notmo.grant", 32'(grant1), 32'h1);
        chk("notmo.idx", 32'(grant_idx1), 32'd1);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("notmo.hold", 32'(grant1), 32'h1);
            chk("notmo.timeout", 32'(timeout1), 32'd0);
            chk("notmo.busy", 32'(busy1), 32'd1);
        end
        req1 = '0;
        step();
        chk("notmo.rel", 32'(grant1), 32'h0);
        chk("notmo.rel_timeout", 32'(timeout1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
